// File: rtl/text_char_buffer.sv
// Character cell buffer for a text display: one-cycle registered reads, single-cell
// writes, and a background sweep that initialises or fills every cell one per cycle.
module text_char_buffer #(
   parameter int                COLS        = 16,
   parameter int                ROWS        = 16,
   parameter int                CODE_W      = 7,
   parameter logic [CODE_W-1:0] SPACE_CODE  = 7'h00,
   parameter logic [CODE_W-1:0] BORDER_CODE = 7'h0e,
   localparam int               CELLS       = COLS * ROWS,
   localparam int               ADDR_W      = $clog2(CELLS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] char_xy,
   output logic [CODE_W-1:0] char_code,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [CODE_W-1:0] wr_data,
   input  logic              fill_req,
   input  logic [CODE_W-1:0] fill_code,
   output logic              busy,
   output logic              wr_drop
);

   // One extra bit so address compares work even when CELLS is a power of two.
   localparam logic [ADDR_W:0] CELLS_X     = (ADDR_W+1)'(CELLS);
   localparam logic [ADDR_W:0] LAST_X      = (ADDR_W+1)'(CELLS - 1);
   localparam logic [ADDR_W:0] BORDER_BASE = (ADDR_W+1)'((ROWS - 1) * COLS);

   typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_FILL} state_e;

   logic [CODE_W-1:0] mem [0:CELLS-1];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [CODE_W-1:0] fill_code_q, fill_code_d;
   logic [CODE_W-1:0] char_code_q, char_code_d;
   logic              busy_q, busy_d;
   logic              wr_drop_q, wr_drop_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [CODE_W-1:0] mem_data;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fill_code_d = fill_code_q;
      wr_drop_d   = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = cnt_q;
      mem_data    = SPACE_CODE;
      // Reads use the pre-write array contents, giving read-first behaviour.
      char_code_d = ({1'b0, char_xy} < CELLS_X) ? mem[char_xy] : SPACE_CODE;

      case (state_q)
         ST_IDLE: begin
            if (wr_en) begin
               if ({1'b0, wr_addr} < CELLS_X) begin
                  mem_we   = 1'b1;
                  mem_addr = wr_addr;
                  mem_data = wr_data;
               end else begin
                  wr_drop_d = 1'b1;
               end
            end
            if (fill_req) begin
               state_d     = ST_FILL;
               cnt_d       = '0;
               fill_code_d = fill_code;
            end
         end
         ST_INIT, ST_FILL: begin
            wr_drop_d = wr_en | fill_req;
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            if (state_q == ST_FILL)
               mem_data = fill_code_q;
            else
               mem_data = ({1'b0, cnt_q} >= BORDER_BASE) ? BORDER_CODE : SPACE_CODE;
            if ({1'b0, cnt_q} == LAST_X) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         fill_code_q <= SPACE_CODE;
         char_code_q <= SPACE_CODE;
         busy_q      <= 1'b1;
         wr_drop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fill_code_q <= fill_code_d;
         char_code_q <= char_code_d;
         busy_q      <= busy_d;
         wr_drop_q   <= wr_drop_d;
      end
   end

   // Array has no reset; the INIT sweep rewrites it after every reset.
   always_ff @(posedge clk) begin
      if (mem_we && rst_n)
         mem[mem_addr] <= mem_data;
   end

   assign char_code = char_code_q;
   assign busy      = busy_q;
   assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_text_char_buffer.sv
// Randomised and directed bench for text_char_buffer: a cell-array reference model
// checked every cycle, plus literal expectations on a 16x16 and a 40x30 instance.
module tb_text_char_buffer;

   localparam int COLS = 16, ROWS = 16, CELLS = COLS * ROWS;
   localparam int BCOLS = 40, BROWS = 30, BCELLS = BCOLS * BROWS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic [7:0] char_xy = '0, wr_addr = '0;
   logic [6:0] wr_data = '0, fill_code = '0, char_code;
   logic       wr_en = 1'b0, fill_req = 1'b0, busy, wr_drop;

   logic        b_rst_n = 1'b0;
   logic [10:0] b_char_xy = '0, b_wr_addr = '0;
   logic [6:0]  b_wr_data = '0, b_fill_code = '0, b_char_code;
   logic        b_wr_en = 1'b0, b_fill_req = 1'b0, b_busy, b_wr_drop;

   int errs = 0, checks = 0;

   text_char_buffer u_dut (
      .clk(clk), .rst_n(rst_n), .char_xy(char_xy), .char_code(char_code),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .fill_req(fill_req), .fill_code(fill_code), .busy(busy), .wr_drop(wr_drop)
   );

   text_char_buffer #(.COLS(BCOLS), .ROWS(BROWS)) u_big (
      .clk(clk), .rst_n(b_rst_n), .char_xy(b_char_xy), .char_code(b_char_code),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .fill_req(b_fill_req), .fill_code(b_fill_code), .busy(b_busy), .wr_drop(b_wr_drop)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: cell array with "known" flags and a pending sweep position.
   logic [6:0] m_cell [CELLS];
   bit         m_known [CELLS];
   bit         m_ok = 0;
   int         sweep_pos = -1;
   bit         sweep_is_fill = 0;
   logic [6:0] sweep_code = '0;
   logic [6:0] e_code = '0;
   bit         e_known = 0, e_busy = 0, e_drop = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_ok = 1; sweep_pos = 0; sweep_is_fill = 0;
         e_code = 7'h00; e_known = 1; e_busy = 1; e_drop = 0;
      end else if (m_ok) begin
         e_code  = m_cell[char_xy];
         e_known = m_known[char_xy];
         if (sweep_pos >= 0) begin
            e_drop = wr_en || fill_req;
            m_cell[sweep_pos]  = sweep_is_fill ? sweep_code :
                                 ((sweep_pos / COLS) == ROWS - 1) ? 7'h0e : 7'h00;
            m_known[sweep_pos] = 1;
            sweep_pos++;
            if (sweep_pos == CELLS) sweep_pos = -1;
         end else begin
            e_drop = 0;
            if (wr_en) begin
               m_cell[wr_addr]  = wr_data;
               m_known[wr_addr] = 1;
            end
            if (fill_req) begin
               sweep_pos = 0; sweep_is_fill = 1; sweep_code = fill_code;
            end
         end
         e_busy = (sweep_pos >= 0);
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("busy", busy, e_busy);
         chk("wr_drop", wr_drop, e_drop);
         if (e_known) chk("char_code", char_code, e_code);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic [7:0] a, input logic [6:0] e);
      char_xy = a;
      tick();
      chk($sformatf("rd_%0h", a), char_code, e);
   endtask

   task automatic wait_idle(input string nm, input int exp_n);
      int n = 0;
      while (busy && n < 5000) begin tick(); n++; end
      chk(nm, n, exp_n);
   endtask

   task automatic b_rd(input logic [10:0] a, input logic [6:0] e);
      b_char_xy = a;
      tick();
      chk($sformatf("big_rd_%0d", a), b_char_code, e);
   endtask

   task automatic default_pattern();
      rd(8'h00, 7'h00); rd(8'hEF, 7'h00); rd(8'hF0, 7'h0e); rd(8'hFF, 7'h0e);
   endtask

   initial begin #500000; $display("FAIL watchdog: simulation timed out"); $fatal; end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_idle("init_cycles", 256);
      default_pattern();

      // Simple write then read back.
      wr_en = 1; wr_addr = 8'h10; wr_data = 7'h4D;
      tick();
      wr_en = 0;
      rd(8'h10, 7'h4D);

      // Same-cycle write and read returns old content.
      wr_en = 1; wr_addr = 8'h20; wr_data = 7'h41; char_xy = 8'h20;
      tick();
      wr_en = 0;
      chk("read_first_old", char_code, 7'h00);
      tick();
      chk("read_first_new", char_code, 7'h41);

      // Fill with a write attempted mid-sweep.
      fill_req = 1; fill_code = 7'h2A;
      tick();
      fill_req = 0;
      chk("fill_busy", busy, 1'b1);
      begin
         int n = 0;
         while (busy && n < 5000) begin
            tick(); n++;
            if (n == 50) begin wr_en = 1; wr_addr = 8'h05; wr_data = 7'h7F; end
            if (n == 51) begin wr_en = 0; chk("fill_wr_drop", wr_drop, 1'b1); end
         end
         chk("fill_cycles", n, 256);
      end
      for (int a = 0; a < CELLS; a++) rd(8'(a), 7'h2A);

      // Reset in the middle of a fill restarts INIT.
      fill_req = 1; fill_code = 7'h33;
      tick();
      fill_req = 0;
      repeat (99) tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      wait_idle("reinit_cycles", 256);
      default_pattern();

      // Randomised traffic, including occasional fills and resets.
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 799) != 0);
         wr_en     = ($urandom_range(0, 2) == 0);
         wr_addr   = 8'($urandom);
         wr_data   = 7'($urandom);
         char_xy   = 8'($urandom);
         fill_req  = ($urandom_range(0, 299) == 0);
         fill_code = 7'($urandom);
         tick();
      end
      rst_n = 1; wr_en = 0; fill_req = 0;
      begin
         int n = 0;
         while (busy && n < 600) begin tick(); n++; end
         chk("rand_settle", busy, 1'b0);
      end

      // Larger geometry: 40x30 cells.
      b_rst_n = 1;
      begin
         int n = 0;
         while (b_busy && n < 5000) begin tick(); n++; end
         chk("big_init_cycles", n, BCELLS);
      end
      b_rd(11'd0, 7'h00);
      b_rd(11'd1159, 7'h00);
      b_rd(11'd1160, 7'h0e);
      b_rd(11'd1199, 7'h0e);
      b_rd(11'd1200, 7'h00);
      b_rd(11'd2047, 7'h00);
      b_wr_en = 1; b_wr_addr = 11'd1200; b_wr_data = 7'h55;
      tick();
      b_wr_en = 0;
      chk("big_oob_drop", b_wr_drop, 1'b1);
      tick();
      chk("big_drop_pulse", b_wr_drop, 1'b0);
      b_rd(11'd1200, 7'h00);
      b_wr_en = 1; b_wr_addr = 11'd1199; b_wr_data = 7'h55;
      tick();
      b_wr_en = 0;
      chk("big_inrange_nodrop", b_wr_drop, 1'b0);
      b_rd(11'd1199, 7'h55);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
